// File: rtl/onehot_ring_if.sv
// Request/status bundle for the one-hot ring sequencer.
// master drives requests and observes status; slave is the sequencer side.
interface onehot_ring_if #(
    parameter int unsigned N_STATES = 7,
    parameter int unsigned IW       = $clog2(N_STATES)
) ();
    logic                adv;
    logic                dir;
    logic                load;
    logic [IW-1:0]       load_idx;
    logic [N_STATES-1:0] state;
    logic [IW-1:0]       idx;
    logic                out;
    logic                wrap;
    logic                err;

    modport master (
        output adv, dir, load, load_idx,
        input  state, idx, out, wrap, err
    );

    modport slave (
        input  adv, dir, load, load_idx,
        output state, idx, out, wrap, err
    );
endinterface

// File: rtl/onehot_ring_fsm.sv
// One-hot ring sequencer with load, bidirectional advance, wrap pulse and Moore decode.
// Define ONEHOT_RING_ERR_EN to add illegal-state detection and the sticky err flag.
module onehot_ring_fsm #(
    parameter int unsigned         N_STATES = 7,
    parameter logic [N_STATES-1:0] OUT_MASK = N_STATES'(1) | (N_STATES'(1) << (N_STATES - 1)),
    parameter int unsigned         IW       = $clog2(N_STATES)
) (
    input  logic               clk,
    input  logic               rst_n,
    onehot_ring_if.slave       bus
);

    localparam logic [IW-1:0] LAST_IDX    = IW'(N_STATES - 1);
    // With only two states every step crosses the ring seam in both directions.
    localparam bit            RING_OF_TWO = (N_STATES == 2);

    logic [N_STATES-1:0] state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                wrap_q, wrap_d;
    logic                out_q, out_d;
    logic                load_ok_c;
    logic                at_last_c;
    logic                at_first_c;

`ifdef ONEHOT_RING_ERR_EN
    logic                err_q, err_d;
    logic                legal_c;
`endif

    // Next-state: load > adv > hold, index kept in binary and re-encoded to one-hot.
    always_comb begin
        load_ok_c  = 32'(bus.load_idx) < N_STATES;
        at_last_c  = (idx_q == LAST_IDX);
        at_first_c = (idx_q == '0);
        idx_d      = idx_q;
        wrap_d     = 1'b0;

        if (bus.load) begin
            if (load_ok_c) begin
                idx_d = bus.load_idx;
            end
        end else if (bus.adv) begin
            if (!bus.dir) begin
                idx_d  = at_last_c ? '0 : idx_q + IW'(1);
                wrap_d = at_last_c || RING_OF_TWO;
            end else begin
                idx_d  = at_first_c ? LAST_IDX : idx_q - IW'(1);
                wrap_d = at_first_c || RING_OF_TWO;
            end
        end

`ifdef ONEHOT_RING_ERR_EN
        legal_c = (state_q != '0) && ((state_q & (state_q - N_STATES'(1))) == '0);
        err_d   = err_q;
        if (!legal_c) begin
            idx_d  = '0;
            wrap_d = 1'b0;
            err_d  = 1'b1;
        end
`endif

        state_d = N_STATES'(1) << idx_d;
        out_d   = |(state_d & OUT_MASK);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= N_STATES'(1);
            idx_q   <= '0;
            wrap_q  <= 1'b0;
            out_q   <= OUT_MASK[0];
`ifdef ONEHOT_RING_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wrap_q  <= wrap_d;
            out_q   <= out_d;
`ifdef ONEHOT_RING_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    assign bus.state = state_q;
    assign bus.idx   = idx_q;
    assign bus.wrap  = wrap_q;
    assign bus.out   = out_q;
`ifdef ONEHOT_RING_ERR_EN
    assign bus.err   = err_q;
`else
    assign bus.err   = 1'b0;
`endif

endmodule

// File: tb/tb_onehot_ring_fsm.sv
// Bench for onehot_ring_fsm: directed scenarios plus randomized traffic against a modular-arithmetic model.
module tb_onehot_ring_fsm;

    localparam int unsigned N = 7;
    localparam logic [6:0]  MASK7 = 7'b1000001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    onehot_ring_if #(.N_STATES(7), .IW(3)) b7 ();
    onehot_ring_if #(.N_STATES(2), .IW(1)) b2 ();

    onehot_ring_fsm #(.N_STATES(7), .IW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b7)
    );

    onehot_ring_fsm #(.N_STATES(2), .OUT_MASK(2'b10), .IW(1)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b2)
    );

    int passed = 0;
    int total  = 0;

    // Reference model state: ring position, last-step wrap, sticky error.
    int m_idx  = 0;
    bit m_wrap = 1'b0;
    bit m_err  = 1'b0;

    function automatic void model_edge(input bit r, input bit a, input bit d, input bit l, input int li);
        int nxt;
        if (r) begin
            m_idx  = 0;
            m_wrap = 1'b0;
            m_err  = 1'b0;
            return;
        end
        m_wrap = 1'b0;
        if (l) begin
            if (li < int'(N)) m_idx = li;
        end else if (a) begin
            nxt    = d ? m_idx - 1 : m_idx + 1;
            m_wrap = (nxt < 0) || (nxt >= int'(N));
            m_idx  = (nxt + int'(N)) % int'(N);
        end
    endfunction

    function automatic logic [11:0] exp_vec();
        logic [6:0] oh;
        oh = 7'(1 << m_idx);
        return {oh, 3'(m_idx), m_wrap, MASK7[m_idx]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit r, input bit a, input bit d, input bit l, input int li);
        rst_n       = !r;
        b7.adv      = a;
        b7.dir      = d;
        b7.load     = l;
        b7.load_idx = 3'(li);
        tick();
        model_edge(r, a, d, l, li);
    endtask

    task automatic test_reset();
        b2.adv = 1'b0; b2.dir = 1'b0; b2.load = 1'b0; b2.load_idx = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 0);
        total++;
        if ({b7.state, b7.idx, b7.wrap, b7.out} !== 12'b0000001_000_0_1)
            $display("FAIL reset_vec: got %b expected %b", {b7.state, b7.idx, b7.wrap, b7.out}, 12'b0000001_000_0_1);
        else passed++;
        total++;
        if (b7.err !== 1'b0) $display("FAIL reset_err: got %b expected 0", b7.err);
        else passed++;
    endtask

    task automatic test_walk_up();
        int seq[7] = '{1, 2, 3, 4, 5, 6, 0};
        // Request raised between edges must not show up before the next edge.
        b7.adv = 1'b1; b7.dir = 1'b0; b7.load = 1'b0; rst_n = 1'b1;
        #2;
        total++;
        if (b7.idx !== 3'd0) $display("FAIL no_comb_path: idx got %0d expected 0", b7.idx);
        else passed++;
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 0);
            total++;
            if (b7.idx !== 3'(seq[i]) || {b7.state, b7.idx, b7.wrap, b7.out} !== exp_vec())
                $display("FAIL walk_up step %0d: got %b expected %b idx %0d", i, {b7.state, b7.idx, b7.wrap, b7.out}, exp_vec(), seq[i]);
            else passed++;
        end
    endtask

    task automatic test_walk_down();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 0);
        total++;
        if ({b7.state, b7.idx, b7.wrap, b7.out} !== 12'b1000000_110_1_1)
            $display("FAIL walk_down_wrap: got %b expected %b", {b7.state, b7.idx, b7.wrap, b7.out}, 12'b1000000_110_1_1);
        else passed++;
        // Reverse every cycle: 6 -> 0 -> 6 -> 5 -> 6
        drive(1'b0, 1'b1, 1'b0, 1'b0, 0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 0);
        total++;
        if (b7.idx !== 3'd6 || {b7.state, b7.idx, b7.wrap, b7.out} !== exp_vec())
            $display("FAIL reversal: got %b expected %b", {b7.state, b7.idx, b7.wrap, b7.out}, exp_vec());
        else passed++;
    endtask

    task automatic test_load();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 3);
        total++;
        if ({b7.state, b7.idx, b7.wrap, b7.out} !== 12'b0001000_011_0_0)
            $display("FAIL load_valid: got %b expected %b", {b7.state, b7.idx, b7.wrap, b7.out}, 12'b0001000_011_0_0);
        else passed++;
        drive(1'b0, 1'b1, 1'b0, 1'b1, 7);
        total++;
        if ({b7.state, b7.idx, b7.wrap, b7.out} !== 12'b0001000_011_0_0)
            $display("FAIL load_invalid: got %b expected %b", {b7.state, b7.idx, b7.wrap, b7.out}, 12'b0001000_011_0_0);
        else passed++;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0);
        total++;
        if ({b7.state, b7.idx, b7.wrap, b7.out} !== exp_vec())
            $display("FAIL hold: got %b expected %b", {b7.state, b7.idx, b7.wrap, b7.out}, exp_vec());
        else passed++;
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 4);
        // Glitch on rst_n between edges must be ignored.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        total++;
        if (b7.idx !== 3'd4) $display("FAIL reset_between_edges: idx got %0d expected 4", b7.idx);
        else passed++;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 2);
        total++;
        if ({b7.state, b7.idx, b7.wrap} !== 11'b0000001_000_0)
            $display("FAIL reset_mid: got %b expected %b", {b7.state, b7.idx, b7.wrap}, 11'b0000001_000_0);
        else passed++;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 0);
        total++;
        if (b7.idx !== 3'd1) $display("FAIL reset_release_adv: idx got %0d expected 1", b7.idx);
        else passed++;
    endtask

    task automatic test_random();
        bit r, a, d, l;
        int li;
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 29) == 0);
            a  = ($urandom_range(0, 3) != 0);
            d  = 1'($urandom);
            l  = ($urandom_range(0, 5) == 0);
            li = int'($urandom_range(0, 7));
            drive(r, a, d, l, li);
            total++;
            if ({b7.state, b7.idx, b7.wrap, b7.out, b7.err} !== {exp_vec(), m_err})
                $display("FAIL random cycle %0d: got %b expected %b", i, {b7.state, b7.idx, b7.wrap, b7.out, b7.err}, {exp_vec(), m_err});
            else passed++;
        end
    endtask

`ifdef ONEHOT_RING_ERR_EN
    task automatic test_err();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 5);
        rst_n = 1'b1; b7.adv = 1'b1; b7.dir = 1'b0; b7.load = 1'b1; b7.load_idx = 3'd3;
        force dut.state_q = 7'b0010100;
        #1;
        release dut.state_q;
        tick();
        m_idx = 0; m_wrap = 1'b0; m_err = 1'b1;
        total++;
        if ({b7.state, b7.idx, b7.wrap, b7.err} !== 12'b0000001_000_0_1)
            $display("FAIL err_detect: got %b expected %b", {b7.state, b7.idx, b7.wrap, b7.err}, 12'b0000001_000_0_1);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 0);
            total++;
            if ({b7.state, b7.idx, b7.wrap, b7.out, b7.err} !== {exp_vec(), 1'b1})
                $display("FAIL err_sticky %0d: got %b expected %b", i, {b7.state, b7.idx, b7.wrap, b7.out, b7.err}, {exp_vec(), 1'b1});
            else passed++;
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0);
        total++;
        if (b7.err !== 1'b0) $display("FAIL err_clear: got %b expected 0", b7.err);
        else passed++;
    endtask
`endif

    task automatic test_n2();
        int exp_idx[6]  = '{1, 0, 1, 0, 1, 0};
        bit exp_out[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0);
        rst_n = 1'b1;
        b7.adv = 1'b0;
        b2.adv = 1'b1;
        b2.load = 1'b0;
        for (int i = 0; i < 6; i++) begin
            b2.dir = (i >= 4);
            tick();
            total++;
            if (b2.idx !== 1'(exp_idx[i]) || b2.out !== exp_out[i] || b2.wrap !== 1'b1 ||
                b2.state !== 2'(1 << exp_idx[i]))
                $display("FAIL n2 step %0d: got idx %0d out %b wrap %b state %b expected idx %0d out %b wrap 1",
                         i, b2.idx, b2.out, b2.wrap, b2.state, exp_idx[i], exp_out[i]);
            else passed++;
        end
        b2.adv = 1'b0;
        tick();
        total++;
        if (b2.wrap !== 1'b0 || b2.idx !== 1'b0)
            $display("FAIL n2_hold: got idx %0d wrap %b expected idx 0 wrap 0", b2.idx, b2.wrap);
        else passed++;
    endtask

    initial begin
        b7.adv = 1'b0; b7.dir = 1'b0; b7.load = 1'b0; b7.load_idx = 3'd0;
        test_reset();
        test_walk_up();
        test_walk_down();
        test_load();
        test_reset_mid();
        test_random();
`ifdef ONEHOT_RING_ERR_EN
        test_err();
`endif
        test_n2();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
